// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) request encoder with one-hot side output, fixed-priority or round-robin pick.
// Latency: req in cycle t (idle) -> out_valid/out_idx/out_onehot registered in cycle t+1; one grant per cycle.
// Backpressure: out_ready low freezes the held grant; req changes are ignored until the handshake.
module rr_priority_encoder #(
  parameter int N     = 4,
  parameter int MODE  = 1,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N-1:0]                 req,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [((($clog2(N)) > 1) ? $clog2(N) : 1)-1:0] out_idx,
  output logic [N-1:0]                 out_onehot,
  output logic [CNT_W-1:0]             grant_cnt
);

  localparam int W = ($clog2(N) > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       ptr_q, ptr_d;
  logic [W-1:0]       idx_q, idx_d;
  logic [N-1:0]       onehot_q, onehot_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               hs;
  logic [W-1:0]       ptr_inc;
  logic [W-1:0]       search_start;
  logic [W:0]         pos;
  logic               win_vld;
  logic [W-1:0]       win_idx;
  logic [N-1:0]       win_onehot;

  // A handshake completes whenever a grant is held and the consumer takes it.
  assign hs = (state_q == HOLD) && out_ready;

  // Pointer after a handshake: one past the index just granted, wrapping N-1 -> 0 for any N.
  assign ptr_inc = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);

  assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;

  // Pick the winner: circular search from the start point (always 0 in fixed-priority mode).
  always_comb begin
    search_start = ptr_q;
    if (MODE == 1 && hs) begin
      search_start = ptr_inc;
    end
    if (MODE != 1) begin
      search_start = '0;
    end
    win_vld = 1'b0;
    win_idx = '0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, search_start} + (W+1)'(k);
      if (pos >= (W+1)'(N)) begin
        pos = pos - (W+1)'(N);
      end
      if (!win_vld && req[pos[W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = pos[W-1:0];
      end
    end
  end

  // Next-state and next-output logic for the IDLE/HOLD controller.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        onehot_d = '0;
        if (win_vld) begin
          idx_d    = win_idx;
          onehot_d = win_onehot;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (MODE == 1) begin
            ptr_d = ptr_inc;
          end
          if (win_vld) begin
            idx_d    = win_idx;
            onehot_d = win_onehot;
          end else begin
            onehot_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = '0;
      end
    endcase
  end

  // State registers; synchronous reset overrides any same-cycle handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign grant_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder: three instances (N=4 fixed, N=4 round-robin, N=5 round-robin).
// Each vector drives one instance for one cycle and checks its registered outputs #1 after the edge.
// Counter wrap and reset-with-ready are hand-written sequences around the vector table.
module tb_rr_priority_encoder;

  localparam int SEL_FP = 0;
  localparam int SEL_RR = 1;
  localparam int SEL_R5 = 2;

  typedef struct {
    int         sel;
    string      name;
    logic       rst_n;
    logic [4:0] req;
    logic       rdy;
    logic       vld;
    logic [2:0] idx;
    logic [4:0] oh;
    logic [7:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_fp, rdy_fp, vld_fp;
  logic [3:0] req_fp, oh_fp;
  logic [1:0] idx_fp;
  logic [7:0] cnt_fp;

  logic       rst_rr, rdy_rr, vld_rr;
  logic [3:0] req_rr, oh_rr;
  logic [1:0] idx_rr;
  logic [7:0] cnt_rr;

  logic       rst_r5, rdy_r5, vld_r5;
  logic [4:0] req_r5, oh_r5;
  logic [2:0] idx_r5;
  logic [7:0] cnt_r5;

  rr_priority_encoder #(.N(4), .MODE(0), .CNT_W(8)) u_fp (
    .clk(clk), .rst_n(rst_fp), .req(req_fp), .out_ready(rdy_fp),
    .out_valid(vld_fp), .out_idx(idx_fp), .out_onehot(oh_fp), .grant_cnt(cnt_fp));

  rr_priority_encoder #(.N(4), .MODE(1), .CNT_W(8)) u_rr (
    .clk(clk), .rst_n(rst_rr), .req(req_rr), .out_ready(rdy_rr),
    .out_valid(vld_rr), .out_idx(idx_rr), .out_onehot(oh_rr), .grant_cnt(cnt_rr));

  rr_priority_encoder #(.N(5), .MODE(1), .CNT_W(8)) u_r5 (
    .clk(clk), .rst_n(rst_r5), .req(req_r5), .out_ready(rdy_r5),
    .out_valid(vld_r5), .out_idx(idx_r5), .out_onehot(oh_r5), .grant_cnt(cnt_r5));

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  function automatic vec_t mk(input int sel, input string name, input logic rst_n,
                              input logic [4:0] req, input logic rdy, input logic vld,
                              input logic [2:0] idx, input logic [4:0] oh, input logic [7:0] cnt);
    vec_t v;
    v.sel = sel; v.name = name; v.rst_n = rst_n; v.req = req; v.rdy = rdy;
    v.vld = vld; v.idx = idx; v.oh = oh; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_dut(input int sel, input string name, input logic vld,
                           input logic [2:0] idx, input logic [4:0] oh, input logic [7:0] cnt);
    logic       a_vld;
    logic [2:0] a_idx;
    logic [4:0] a_oh;
    logic [7:0] a_cnt;
    case (sel)
      SEL_FP:  begin a_vld = vld_fp; a_idx = {1'b0, idx_fp}; a_oh = {1'b0, oh_fp}; a_cnt = cnt_fp; end
      SEL_RR:  begin a_vld = vld_rr; a_idx = {1'b0, idx_rr}; a_oh = {1'b0, oh_rr}; a_cnt = cnt_rr; end
      default: begin a_vld = vld_r5; a_idx = idx_r5;         a_oh = oh_r5;         a_cnt = cnt_r5; end
    endcase
    check({name, ".out_valid"},  32'(a_vld), 32'(vld));
    check({name, ".out_idx"},    32'(a_idx), 32'(idx));
    check({name, ".out_onehot"}, 32'(a_oh),  32'(oh));
    check({name, ".grant_cnt"},  32'(a_cnt), 32'(cnt));
  endtask

  task automatic idle_all();
    rst_fp = 1'b1; req_fp = '0; rdy_fp = 1'b0;
    rst_rr = 1'b1; req_rr = '0; rdy_rr = 1'b0;
    rst_r5 = 1'b1; req_r5 = '0; rdy_r5 = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    idle_all();
    case (v.sel)
      SEL_FP:  begin rst_fp = v.rst_n; req_fp = v.req[3:0]; rdy_fp = v.rdy; end
      SEL_RR:  begin rst_rr = v.rst_n; req_rr = v.req[3:0]; rdy_rr = v.rdy; end
      default: begin rst_r5 = v.rst_n; req_r5 = v.req;      rdy_r5 = v.rdy; end
    endcase
    @(posedge clk);
    #1;
    check_dut(v.sel, v.name, v.vld, v.idx, v.oh, v.cnt);
  endtask

  logic [7:0] exp_cnt;

  initial begin
    // Round-robin N=4: first grant after reset, rotation, backpressure, drain, mid-run reset.
    vecs.push_back(mk(SEL_RR, "rr_first",   1'b1, 5'b01111, 1'b1, 1'b1, 3'd0, 5'b00001, 8'd0));
    vecs.push_back(mk(SEL_RR, "rr_rot1",    1'b1, 5'b01111, 1'b1, 1'b1, 3'd1, 5'b00010, 8'd1));
    vecs.push_back(mk(SEL_RR, "rr_rot2",    1'b1, 5'b01111, 1'b1, 1'b1, 3'd2, 5'b00100, 8'd2));
    vecs.push_back(mk(SEL_RR, "rr_rot3",    1'b1, 5'b01111, 1'b1, 1'b1, 3'd3, 5'b01000, 8'd3));
    vecs.push_back(mk(SEL_RR, "rr_rot0",    1'b1, 5'b01111, 1'b1, 1'b1, 3'd0, 5'b00001, 8'd4));
    vecs.push_back(mk(SEL_RR, "rr_rot1b",   1'b1, 5'b01111, 1'b1, 1'b1, 3'd1, 5'b00010, 8'd5));
    vecs.push_back(mk(SEL_RR, "bp_grant2",  1'b1, 5'b00100, 1'b1, 1'b1, 3'd2, 5'b00100, 8'd6));
    vecs.push_back(mk(SEL_RR, "bp_hold1",   1'b1, 5'b00100, 1'b0, 1'b1, 3'd2, 5'b00100, 8'd6));
    vecs.push_back(mk(SEL_RR, "bp_hold2",   1'b1, 5'b00001, 1'b0, 1'b1, 3'd2, 5'b00100, 8'd6));
    vecs.push_back(mk(SEL_RR, "bp_hold3",   1'b1, 5'b00001, 1'b0, 1'b1, 3'd2, 5'b00100, 8'd6));
    vecs.push_back(mk(SEL_RR, "bp_release", 1'b1, 5'b00001, 1'b1, 1'b1, 3'd0, 5'b00001, 8'd7));
    vecs.push_back(mk(SEL_RR, "drain",      1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b00000, 8'd8));
    vecs.push_back(mk(SEL_RR, "idle_rdy",   1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b00000, 8'd8));
    vecs.push_back(mk(SEL_RR, "idle_ptr1",  1'b1, 5'b01111, 1'b0, 1'b1, 3'd1, 5'b00010, 8'd8));
    vecs.push_back(mk(SEL_RR, "mid_reset",  1'b0, 5'b01111, 1'b1, 1'b0, 3'd0, 5'b00000, 8'd0));
    vecs.push_back(mk(SEL_RR, "post_rst0",  1'b1, 5'b01111, 1'b0, 1'b1, 3'd0, 5'b00001, 8'd0));
    vecs.push_back(mk(SEL_RR, "post_rst1",  1'b1, 5'b01111, 1'b1, 1'b1, 3'd1, 5'b00010, 8'd1));
    // Fixed priority N=4: lowest set bit every cycle, no rotation.
    vecs.push_back(mk(SEL_FP, "fp_first",   1'b1, 5'b01010, 1'b1, 1'b1, 3'd1, 5'b00010, 8'd0));
    vecs.push_back(mk(SEL_FP, "fp_rep1",    1'b1, 5'b01010, 1'b1, 1'b1, 3'd1, 5'b00010, 8'd1));
    vecs.push_back(mk(SEL_FP, "fp_rep2",    1'b1, 5'b01010, 1'b1, 1'b1, 3'd1, 5'b00010, 8'd2));
    vecs.push_back(mk(SEL_FP, "fp_rep3",    1'b1, 5'b01010, 1'b1, 1'b1, 3'd1, 5'b00010, 8'd3));
    vecs.push_back(mk(SEL_FP, "fp_only3",   1'b1, 5'b01000, 1'b1, 1'b1, 3'd3, 5'b01000, 8'd4));
    vecs.push_back(mk(SEL_FP, "fp_low1",    1'b1, 5'b01110, 1'b1, 1'b1, 3'd1, 5'b00010, 8'd5));
    // Round-robin N=5: wrap from 4 back to 0.
    vecs.push_back(mk(SEL_R5, "r5_first",   1'b1, 5'b10001, 1'b1, 1'b1, 3'd0, 5'b00001, 8'd0));
    vecs.push_back(mk(SEL_R5, "r5_to4",     1'b1, 5'b10001, 1'b1, 1'b1, 3'd4, 5'b10000, 8'd1));
    vecs.push_back(mk(SEL_R5, "r5_wrap0",   1'b1, 5'b10001, 1'b1, 1'b1, 3'd0, 5'b00001, 8'd2));
    vecs.push_back(mk(SEL_R5, "r5_to4b",    1'b1, 5'b10001, 1'b1, 1'b1, 3'd4, 5'b10000, 8'd3));
    vecs.push_back(mk(SEL_R5, "r5_only4a",  1'b1, 5'b10000, 1'b1, 1'b1, 3'd4, 5'b10000, 8'd4));
    vecs.push_back(mk(SEL_R5, "r5_only4b",  1'b1, 5'b10000, 1'b1, 1'b1, 3'd4, 5'b10000, 8'd5));
    vecs.push_back(mk(SEL_R5, "r5_only4c",  1'b1, 5'b10000, 1'b1, 1'b1, 3'd4, 5'b10000, 8'd6));
    vecs.push_back(mk(SEL_R5, "r5_ptr0",    1'b1, 5'b00010, 1'b1, 1'b1, 3'd1, 5'b00010, 8'd7));
    vecs.push_back(mk(SEL_R5, "r5_ptr2",    1'b1, 5'b00011, 1'b1, 1'b1, 3'd0, 5'b00001, 8'd8));

    // Reset held for two edges with every request up and the consumer ready.
    rst_fp = 1'b0; req_fp = 4'b1111; rdy_fp = 1'b1;
    rst_rr = 1'b0; req_rr = 4'b1111; rdy_rr = 1'b1;
    rst_r5 = 1'b0; req_r5 = 5'b11111; rdy_r5 = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      check_dut(SEL_FP, "rst_fp", 1'b0, 3'd0, 5'b0, 8'd0);
      check_dut(SEL_RR, "rst_rr", 1'b0, 3'd0, 5'b0, 8'd0);
      check_dut(SEL_R5, "rst_r5", 1'b0, 3'd0, 5'b0, 8'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i]);
      if (vecs[i].name == "fp_low1") begin
        // Keep the fixed-priority instance granting until its counter wraps past 255.
        exp_cnt = 8'd5;
        for (int c = 0; c < 260; c++) begin
          idle_all();
          req_fp = 4'b1010;
          rdy_fp = 1'b1;
          @(posedge clk);
          #1;
          exp_cnt = exp_cnt + 8'd1;
          check("fp_wrap.grant_cnt", 32'(cnt_fp), 32'(exp_cnt));
          check("fp_wrap.out_idx",   32'(idx_fp), 32'd1);
        end
      end
    end

    idle_all();
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_priority_encoder.md
# rr_priority_encoder

Parametrised, registered N-to-log2(N) encoder with a one-hot decoded side output, selectable fixed-priority or round-robin arbitration, and a valid/ready output handshake. It supersedes the fixed 2-bit combinational encode/decode block. It sits between a bank of level-sensitive request lines and a single downstream consumer that accepts one granted index per handshake. A wrapping grant counter is included for bring-up and debug.

## Interface
- N, default 4: number of request lines, N >= 2.
- MODE, default 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- CNT_W, default 8: width of the grant counter.
- W (localparam) = max(1, clog2(N)): index width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  N  level-sensitive request vector, sampled every cycle.
- out_ready  in  1  consumer accepts the current grant.
- out_valid  out  1  grant registers hold a valid grant.
- out_idx  out  W  binary index of the granted request.
- out_onehot  out  N  one-hot decode of out_idx, i.e. 1 << out_idx; all zero when out_valid = 0.
- grant_cnt  out  CNT_W  count of completed handshakes, wraps modulo 2^CNT_W.

## Operation
- Internal state:
  - 1-bit FSM: IDLE (out_valid = 0) or HOLD (out_valid = 1).
  - Round-robin pointer ptr, width W, range 0..N-1.
- Winner selection (combinational from the current req and ptr):
  - MODE 0: lowest set index. ptr stays 0 permanently.
  - MODE 1: first set bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - No winner when req = 0.
- IDLE:
  - If req != 0, load the winner into out_idx/out_onehot and go to HOLD.
  - Otherwise stay in IDLE, with outputs unchanged and out_onehot = 0.
- HOLD, out_ready = 0:
  - out_idx, out_onehot and out_valid hold stable.
  - Changes on req, including the granted bit dropping, are ignored.
- HOLD, out_ready = 1 (handshake):
  - grant_cnt increments.
  - MODE 1: ptr becomes (out_idx + 1) mod N. For non-power-of-two N, wrap N-1 -> 0 explicitly.
  - If req != 0 in the same cycle, load the winner, stay in HOLD and keep out_valid = 1 (back-to-back, one grant per cycle). Selection uses the updated ptr, i.e. the search starts at out_idx + 1.
  - If req = 0, go to IDLE, clear out_valid and clear out_onehot.
- The block never clears or acknowledges req. A requester that keeps its bit high is re-granted:
  - MODE 0: every cycle, while it is the lowest set bit.
  - MODE 1: once per rotation.
- out_ready while in IDLE is ignored. No count, no ptr change.
- Reset (rst_n = 0 at a clock edge) takes priority over every other event, including a handshake in the same cycle:
  - out_valid = 0, out_idx = 0, out_onehot = 0, ptr = 0, grant_cnt = 0, FSM = IDLE.

## Timing
- Latency: req asserted in cycle t (block in IDLE) -> out_valid = 1 with the grant in cycle t+1.
- Throughput: one grant per cycle while out_ready = 1 and req != 0.
- Handshake completes on a rising edge where out_valid = 1 and out_ready = 1. out_ready may depend combinationally on out_valid; out_valid does not depend on out_ready.
- Reset is synchronous: outputs reach reset values at the first rising edge with rst_n = 0. The first possible grant is one cycle after the first edge with rst_n = 1.
- All outputs are driven directly from registers. There is no combinational path from req or out_ready to any output.
- grant_cnt at 2^CNT_W - 1 plus a handshake -> 0, with no flag.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with req = 4'b1111 and out_ready = 1 -> out_valid = 0, out_idx = 0, out_onehot = 0, grant_cnt = 0 throughout. First grant appears one cycle after release: MODE 1 gives idx 0.
- Fixed priority, N = 4, MODE 0, req = 4'b1010 held, out_ready = 1 -> out_idx = 1, out_onehot = 4'b0010 every cycle. grant_cnt increments by 1 per cycle.
- Round-robin, N = 4, MODE 1, req = 4'b1111 held, out_ready = 1 -> out_idx sequence 0,1,2,3,0,1 on consecutive cycles. out_onehot always equals 1 << out_idx.
- Backpressure: grant out_idx = 2, then out_ready = 0 for 3 cycles while req changes 4'b0100 -> 4'b0001 -> outputs held at idx 2 / 4'b0100. On out_ready = 1, the next grant is idx 0 (MODE 1, ptr = 3 wraps). grant_cnt increases by exactly 1 per handshake.
- Non-power-of-two wrap, N = 5, MODE 1:
  - req = 5'b10001 held, out_ready = 1 -> idx 0,4,0,4.
  - req = 5'b10000 -> idx 4 repeats; ptr never exceeds 4.
- Drain and mid-operation reset:
  - req drops to 0 at a handshake -> out_valid = 0 and out_onehot = 0 next cycle.
  - Separately, rst_n = 0 during HOLD with out_ready = 1 -> next cycle all outputs 0 and grant_cnt = 0 (no count for that cycle); ptr = 0, so the next MODE 1 grant with req = 1111 is idx 0.
